// File: rtl/id2exe_skid_buffer.sv
// ID->EXE receiver: 2-entry skid buffer with flush, NOP-ified idle payload
// and a saturating EXE back-pressure counter.
package core_pkg;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CSR_AW = 12;

   typedef enum logic [3:0] {
      EXE_NOP, EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_XOR,
      EXE_SLL, EXE_SRL, EXE_SRA, EXE_SLT, EXE_SLTU
   } exe_ctrl_t;

   typedef enum logic [1:0] {MEM_IDLE, MEM_LD, MEM_ST} mem_ctrl_t;
   typedef enum logic [1:0] {CSR_IDLE, CSR_RW, CSR_RS, CSR_RC} csr_ctrl_t;
   typedef enum logic [1:0] {GPR_IDLE, GPR_WR_ALU, GPR_WR_MEM, GPR_WR_PC} gpr_ctrl_t;
   typedef enum logic [1:0] {PC_INC, PC_BR, PC_JAL, PC_JALR} pc_ctrl_t;
endpackage

package id2exe_pkg;
   import core_pkg::*;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   op1;
      logic [XLEN-1:0]   op2;
      logic [XLEN-1:0]   op3;
      logic [CSR_AW-1:0] csr_waddr;
      logic [REG_AW-1:0] rd;
      exe_ctrl_t         exe_ctrl;
      mem_ctrl_t         mem_ctrl;
      csr_ctrl_t         csr_ctrl;
      gpr_ctrl_t         gpr_ctrl;
      pc_ctrl_t          pc_ctrl;
   } id2exe_t;

   // Harmless bundle: no register, memory, CSR or PC side effect.
   localparam id2exe_t ID2EXE_NOP = '{
      pc:        '0,
      op1:       '0,
      op2:       '0,
      op3:       '0,
      csr_waddr: '0,
      rd:        '0,
      exe_ctrl:  EXE_NOP,
      mem_ctrl:  MEM_IDLE,
      csr_ctrl:  CSR_IDLE,
      gpr_ctrl:  GPR_IDLE,
      pc_ctrl:   PC_INC
   };
endpackage

module id2exe_skid_buffer
   import id2exe_pkg::*;
#(
   parameter int unsigned STALL_CNT_WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       id_valid_i,
   output logic                       id_ready_o,
   input  id2exe_t                    id_payload_i,
   output logic                       exe_valid_o,
   input  logic                       exe_ready_i,
   output id2exe_t                    exe_payload_o,
   input  logic                       flush_i,
   output logic [1:0]                 occupancy_o,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t                     state;
   id2exe_t                    head;
   id2exe_t                    skid;
   logic                       id_ready;
   logic                       exe_valid;
   logic [1:0]                 occupancy;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt;
   logic                       acc;
   logic                       con;

   assign acc = id_valid_i & id_ready;
   assign con = exe_valid & exe_ready_i;

   // head is kept at NOP whenever empty, so it drives the output directly.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         state     <= EMPTY;
         head      <= ID2EXE_NOP;
         skid      <= ID2EXE_NOP;
         id_ready  <= 1'b1;
         exe_valid <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (acc) begin
                  head      <= id_payload_i;
                  state     <= ONE;
                  exe_valid <= 1'b1;
                  occupancy <= 2'd1;
               end
            end
            ONE: begin
               if (acc && con) begin
                  head <= id_payload_i;
               end else if (acc) begin
                  skid      <= id_payload_i;
                  state     <= FULL;
                  id_ready  <= 1'b0;
                  occupancy <= 2'd2;
               end else if (con) begin
                  head      <= ID2EXE_NOP;
                  state     <= EMPTY;
                  exe_valid <= 1'b0;
                  occupancy <= 2'd0;
               end
            end
            FULL: begin
               if (con) begin
                  head      <= skid;
                  skid      <= ID2EXE_NOP;
                  state     <= ONE;
                  id_ready  <= 1'b1;
                  occupancy <= 2'd1;
               end
            end
            default: begin
               state     <= EMPTY;
               head      <= ID2EXE_NOP;
               skid      <= ID2EXE_NOP;
               id_ready  <= 1'b1;
               exe_valid <= 1'b0;
               occupancy <= 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
      end else if (exe_valid && !exe_ready_i && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign id_ready_o    = id_ready;
   assign exe_valid_o   = exe_valid;
   assign exe_payload_o = head;
   assign occupancy_o   = occupancy;
   assign stall_cnt_o   = stall_cnt;

endmodule
